motion_frame_sink: RTL
======================

MOTION_FRAME_SINK -- requirements
Module: motion_frame_sink

Interface
REQ-001 Parameters SHALL be: WIDTH, default 768, pixels per row; HEIGHT, default 576, rows per frame; THRESH, default 8'h80, motion threshold applied to pixel byte [7:0].
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle pulse that begins consumption of one frame.
REQ-005 z_empty  in  1  output-FIFO empty flag (first-word-fall-through).
REQ-006 z_dout  in  24  pixel at FIFO head; valid whenever z_empty=0.
REQ-007 z_rd_en  out  1  pop strobe to the output FIFO.
REQ-008 busy  out  1  high while a frame is being consumed.
REQ-009 frame_done  out  1  one-cycle pulse at frame completion.
REQ-010 motion_count  out  19  number of motion pixels in the last completed frame.
REQ-011 motion_valid  out  1  high if the last completed frame had motion_count > 0.
REQ-012 x_min, x_max, y_min, y_max  out  10 each  motion bounding box of the last completed frame.

Function
REQ-013 States SHALL be IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on start=1; entering RUN SHALL clear the accumulators and the x/y counters to 0.
REQ-015 RUN -> DONE in the cycle after the pop of pixel x=WIDTH-1, y=HEIGHT-1.
REQ-016 DONE -> IDLE unconditionally after one cycle; frame_done=1 only in DONE.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 z_rd_en SHALL be combinational: (state==RUN) && !z_empty.
REQ-019 A pixel is consumed exactly in a cycle with z_rd_en=1; z_dout is sampled in that same cycle.
REQ-020 x increments per consumed pixel and wraps to 0 at WIDTH-1, at which point y increments.
REQ-021 With z_empty=1, counters and accumulators SHALL hold; gaps of any length are legal.
REQ-022 A pixel is a motion pixel iff z_dout[7:0] >= THRESH (unsigned).
REQ-023 For each motion pixel:
  - the count SHALL increment by 1;
  - the bounding box SHALL expand to min/max of the current x and y.
REQ-024 The first motion pixel of a frame SHALL initialise all four box bounds.
REQ-025 Output registers (count, valid, box) SHALL load from the accumulators on the RUN->DONE edge and hold until the next DONE.
REQ-026 A frame with no motion SHALL report count 0, motion_valid 0 and all box fields 0.
REQ-027 busy SHALL equal (state==RUN).
REQ-028 Latency from the last pop to frame_done SHALL be 1 cycle; results are valid in the frame_done cycle.

Reset
REQ-029 reset=0 SHALL immediately force:
  - state IDLE;
  - x, y and all accumulators 0;
  - all outputs 0 (z_rd_en therefore 0).
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done; the next start begins a fresh frame, and stale FIFO contents are the system's concern.

Structure
REQ-031 Package motion_detect_pkg SHALL hold WIDTH/HEIGHT defaults, PIXEL_W=24, COORD_W=10, COUNT_W=19 and the state enum.
REQ-032 The running count/min/max logic SHALL be a sub-module, motion_bbox_acc (clear, update, x, y inputs), instantiated once.

Verification
REQ-033 Start followed by 442368 pixels of 0x000000, z_empty=0 -> frame_done exactly 1 cycle after the last pop; count 0, valid 0, box 0.
REQ-034 Single pixel 0xFFFFFF at stream index 769, all others 0 -> count 1, valid 1, box x 1..1, y 1..1.
REQ-035 Threshold check: index 0 = 0x00007F, index 442367 = 0x000080 -> count 1, box x 767..767, y 575..575.
REQ-036 z_empty toggled every cycle -> z_rd_en never high while z_empty=1; results identical to REQ-034; frame_done after about 2x the cycles.
REQ-037 Second start pulse mid-RUN -> ignored: no counter clear and one frame_done only.
REQ-038 reset=0 after 1000 pops -> all outputs 0 at once, no frame_done; a subsequent clean frame yields correct results.

Source files
------------

// File: rtl/motion_detect_pkg.sv
// rtl/motion_detect_pkg.sv - shared sizes and state encoding for the motion frame sink
package motion_detect_pkg;
   localparam int WIDTH_DEFAULT  = 768;
   localparam int HEIGHT_DEFAULT = 576;
   localparam int PIXEL_W        = 24;
   localparam int COORD_W        = 10;
   localparam int COUNT_W        = 19;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/motion_bbox_acc.sv
// rtl/motion_bbox_acc.sv - running motion pixel count and bounding box for one frame
module motion_bbox_acc
   import motion_detect_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               update,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [COUNT_W-1:0] count_next,
   output logic [COORD_W-1:0] x_min_next,
   output logic [COORD_W-1:0] x_max_next,
   output logic [COORD_W-1:0] y_min_next,
   output logic [COORD_W-1:0] y_max_next
);
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
   logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;

   always_comb begin
      count_d = count_q;
      x_min_d = x_min_q;
      x_max_d = x_max_q;
      y_min_d = y_min_q;
      y_max_d = y_max_q;
      if (clear) begin
         count_d = '0;
         x_min_d = '0;
         x_max_d = '0;
         y_min_d = '0;
         y_max_d = '0;
      end else if (update) begin
         count_d = count_q + 1'b1;
         // A zero count means the box still holds its cleared zeros, not real bounds
         if (count_q == '0) begin
            x_min_d = x;
            x_max_d = x;
            y_min_d = y;
            y_max_d = y;
         end else begin
            x_min_d = (x < x_min_q) ? x : x_min_q;
            x_max_d = (x > x_max_q) ? x : x_max_q;
            y_min_d = (y < y_min_q) ? y : y_min_q;
            y_max_d = (y > y_max_q) ? y : y_max_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         x_min_q <= '0;
         x_max_q <= '0;
         y_min_q <= '0;
         y_max_q <= '0;
      end else begin
         count_q <= count_d;
         x_min_q <= x_min_d;
         x_max_q <= x_max_d;
         y_min_q <= y_min_d;
         y_max_q <= y_max_d;
      end
   end

   assign count_next = count_d;
   assign x_min_next = x_min_d;
   assign x_max_next = x_max_d;
   assign y_min_next = y_min_d;
   assign y_max_next = y_max_d;
endmodule

// File: rtl/motion_frame_sink.sv
// rtl/motion_frame_sink.sv - drains one frame from a FWFT FIFO and reports its motion statistics
module motion_frame_sink
   import motion_detect_pkg::*;
#(
   parameter int         WIDTH  = WIDTH_DEFAULT,
   parameter int         HEIGHT = HEIGHT_DEFAULT,
   parameter logic [7:0] THRESH = 8'h80
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               z_empty,
   input  logic [PIXEL_W-1:0] z_dout,
   output logic               z_rd_en,
   output logic               busy,
   output logic               frame_done,
   output logic [COUNT_W-1:0] motion_count,
   output logic               motion_valid,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max
);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               valid_q, valid_d;
   logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
   logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;

   logic               acc_clear, acc_update, is_motion;
   logic [COUNT_W-1:0] acc_count;
   logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
   logic               unused_pixel_hi;

   assign unused_pixel_hi = ^z_dout[PIXEL_W-1:8];
   assign z_rd_en    = (state_q == ST_RUN) && !z_empty;
   assign is_motion  = (z_dout[7:0] >= THRESH);
   assign acc_clear  = (state_q == ST_IDLE) && start;
   assign acc_update = z_rd_en && is_motion;

   motion_bbox_acc u_acc (
      .clock      (clock),
      .reset      (reset),
      .clear      (acc_clear),
      .update     (acc_update),
      .x          (x_q),
      .y          (y_q),
      .count_next (acc_count),
      .x_min_next (acc_x_min),
      .x_max_next (acc_x_max),
      .y_min_next (acc_y_min),
      .y_max_next (acc_y_max)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      count_d = count_q;
      valid_d = valid_q;
      x_min_d = x_min_q;
      x_max_d = x_max_q;
      y_min_d = y_min_q;
      y_max_d = y_max_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ST_RUN: begin
            if (z_rd_en) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               // Results take the accumulator's next value so the last pixel is included
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  state_d = ST_DONE;
                  count_d = acc_count;
                  valid_d = (acc_count != '0);
                  x_min_d = acc_x_min;
                  x_max_d = acc_x_max;
                  y_min_d = acc_y_min;
                  y_max_d = acc_y_max;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         x_min_q <= '0;
         x_max_q <= '0;
         y_min_q <= '0;
         y_max_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         count_q <= count_d;
         valid_q <= valid_d;
         x_min_q <= x_min_d;
         x_max_q <= x_max_d;
         y_min_q <= y_min_d;
         y_max_q <= y_max_d;
      end
   end

   assign busy         = (state_q == ST_RUN);
   assign frame_done   = (state_q == ST_DONE);
   assign motion_count = count_q;
   assign motion_valid = valid_q;
   assign x_min        = x_min_q;
   assign x_max        = x_max_q;
   assign y_min        = y_min_q;
   assign y_max        = y_max_q;
endmodule
